// File: rtl/int_wb_pkg.sv
// Shared types and the round-robin picker for the integer writeback arbiter.
package int_wb_pkg;

   localparam int PKG_DATA_W = 32;
   localparam int PKG_PRF_W  = 6;
   localparam int PKG_ROB_W  = 5;
   localparam int MAX_FU     = 16;
   localparam int FU_IDX_W   = 4;

   typedef struct packed {
      logic [PKG_DATA_W-1:0] data;
      logic [PKG_PRF_W-1:0]  dest;
      logic                  wb;
      logic [PKG_ROB_W-1:0]  rob;
   } wb_entry_t;

   typedef struct packed {
      logic                found;
      logic [FU_IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req in the scan order start, start+1, ... mod n.
   function automatic rr_pick_t rr_pick(input logic [MAX_FU-1:0] req,
                                        input logic [FU_IDX_W-1:0] start,
                                        input int n);
      rr_pick_t res;
      int       idx;
      res = '0;
      for (int i = 0; i < MAX_FU; i++) begin
         if (i < n && !res.found) begin
            idx = int'(start) + i;
            if (idx >= n) idx = idx - n;
            if (req[idx[FU_IDX_W-1:0]]) begin
               res.found = 1'b1;
               res.idx   = idx[FU_IDX_W-1:0];
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/int_wb_fifo.sv
// Per-channel result FIFO: power-of-two depth, pointers wrap naturally, flush empties it.
module int_wb_fifo #(
   parameter int FIFO_DEPTH = 2,
   parameter int W          = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] head_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int PW = $clog2(FIFO_DEPTH);

   logic [W-1:0]  mem_q [FIFO_DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [PW:0]   cnt_q, cnt_d;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (PW+1)'(FIFO_DEPTH));
   assign head_o  = mem_q[rd_q];

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_i) wr_d = wr_q + 1'b1;
         if (pop_i)  rd_d = rd_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: an entry is only visible once counted.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/int_wb_arbiter.sv
// Merges NUM_FU result channels onto NUM_WB writeback/completion ports with round-robin grant.
// Optional same-cycle bypass of empty channels is enabled by defining INT_WB_BYPASS_EN.
module int_wb_arbiter #(
   parameter int NUM_FU     = 4,
   parameter int NUM_WB     = 2,
   parameter int FIFO_DEPTH = 2,
   parameter int DATA_W     = 32,
   parameter int PRF_W      = 6,
   parameter int ROB_W      = 5
) (
   input  logic                     cpu_clock_i,
   input  logic                     cpu_resetn_i,
   input  logic                     flush_i,
   input  logic [NUM_FU-1:0]        fu_valid_i,
   output logic [NUM_FU-1:0]        fu_ready_o,
   input  logic [NUM_FU*DATA_W-1:0] fu_data_i,
   input  logic [NUM_FU*PRF_W-1:0]  fu_dest_i,
   input  logic [NUM_FU-1:0]        fu_wb_i,
   input  logic [NUM_FU*ROB_W-1:0]  fu_rob_i,
   output logic [NUM_WB-1:0]        wkp_valid_o,
   output logic [NUM_WB*PRF_W-1:0]  wkp_dest_o,
   output logic [NUM_WB-1:0]        wb_wen_o,
   output logic [NUM_WB*DATA_W-1:0] wb_data_o,
   output logic [NUM_WB*PRF_W-1:0]  wb_dest_o,
   output logic [NUM_WB-1:0]        cmp_valid_o,
   output logic [NUM_WB*ROB_W-1:0]  cmp_rob_o
);

   import int_wb_pkg::*;

   localparam int E_W = DATA_W + PRF_W + 1 + ROB_W;

   logic [NUM_FU-1:0]   empty, full, push, pop, cand, byp, gnt;
   logic [E_W-1:0]      head     [NUM_FU];
   logic [E_W-1:0]      in_ent   [NUM_FU];
   logic [E_W-1:0]      cand_ent [NUM_FU];
   logic [NUM_WB-1:0]   port_vld;
   logic [E_W-1:0]      port_ent [NUM_WB];
   logic [MAX_FU-1:0]   req;
   rr_pick_t            pick;

   logic [FU_IDX_W-1:0]      rr_q, rr_d;
   logic [NUM_WB-1:0]        cmp_q, cmp_d, wen_q, wen_d;
   logic [NUM_WB*DATA_W-1:0] data_q;
   logic [NUM_WB*PRF_W-1:0]  dest_q;
   logic [NUM_WB*ROB_W-1:0]  rob_q;

   for (genvar i = 0; i < NUM_FU; i++) begin : g_ch
      assign in_ent[i] = {fu_data_i[i*DATA_W +: DATA_W], fu_dest_i[i*PRF_W +: PRF_W],
                          fu_wb_i[i], fu_rob_i[i*ROB_W +: ROB_W]};
`ifdef INT_WB_BYPASS_EN
      assign byp[i] = empty[i] & fu_valid_i[i];
`else
      assign byp[i] = 1'b0;
`endif
      assign cand[i]     = ~empty[i] | byp[i];
      assign cand_ent[i] = empty[i] ? in_ent[i] : head[i];
      // A bypassed result that wins a port must not also land in the FIFO.
      assign push[i]     = fu_valid_i[i] & ~full[i] & ~flush_i & ~(byp[i] & gnt[i]);
      assign pop[i]      = gnt[i] & ~empty[i];
      assign fu_ready_o[i] = ~full[i];

      int_wb_fifo #(
         .FIFO_DEPTH(FIFO_DEPTH),
         .W         (E_W)
      ) u_fifo (
         .clk_i  (cpu_clock_i),
         .rst_ni (cpu_resetn_i),
         .flush_i(flush_i),
         .push_i (push[i]),
         .pop_i  (pop[i]),
         .din_i  (in_ent[i]),
         .head_o (head[i]),
         .empty_o(empty[i]),
         .full_o (full[i])
      );
   end

   always_comb begin
      req      = MAX_FU'(cand);
      gnt      = '0;
      port_vld = '0;
      rr_d     = rr_q;
      pick     = '0;
      for (int k = 0; k < NUM_WB; k++) begin
         port_ent[k] = '0;
         pick = rr_pick(req, rr_q, NUM_FU);
         if (pick.found) begin
            port_vld[k] = 1'b1;
            req  = req & ~(MAX_FU'(1) << pick.idx);
            rr_d = (pick.idx == FU_IDX_W'(NUM_FU-1)) ? '0 : pick.idx + 1'b1;
            for (int i = 0; i < NUM_FU; i++) begin
               if (pick.idx == FU_IDX_W'(i)) begin
                  gnt[i]      = 1'b1;
                  port_ent[k] = cand_ent[i];
               end
            end
         end
      end
      if (flush_i) begin
         gnt      = '0;
         port_vld = '0;
         rr_d     = rr_q;
      end
   end

   for (genvar k = 0; k < NUM_WB; k++) begin : g_port
      assign wkp_valid_o[k] = port_vld[k] & port_ent[k][ROB_W] &
                              (port_ent[k][ROB_W+1 +: PRF_W] != '0);
      assign wkp_dest_o[k*PRF_W +: PRF_W] = port_ent[k][ROB_W+1 +: PRF_W];
   end

   assign cmp_d = port_vld;
   assign wen_d = wkp_valid_o;

   always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
      if (!cpu_resetn_i) begin
         rr_q   <= '0;
         cmp_q  <= '0;
         wen_q  <= '0;
         data_q <= '0;
         dest_q <= '0;
         rob_q  <= '0;
      end else begin
         rr_q  <= rr_d;
         cmp_q <= cmp_d;
         wen_q <= wen_d;
         for (int k = 0; k < NUM_WB; k++) begin
            if (port_vld[k]) begin
               data_q[k*DATA_W +: DATA_W] <= port_ent[k][E_W-1 -: DATA_W];
               dest_q[k*PRF_W +: PRF_W]   <= port_ent[k][ROB_W+1 +: PRF_W];
               rob_q[k*ROB_W +: ROB_W]    <= port_ent[k][ROB_W-1:0];
            end
         end
      end
   end

   assign cmp_valid_o = cmp_q;
   assign wb_wen_o    = wen_q;
   assign wb_data_o   = data_q;
   assign wb_dest_o   = dest_q;
   assign cmp_rob_o   = rob_q;

endmodule
